ps2_keymap: RTL and testbench
=============================

Name: ps2_keymap

Overview:
Converts the PS/2 scan-code byte stream from the PS/2 receiver into ASCII/ANSI bytes for the terminal core. It tracks make/break prefixes, extended prefixes and modifier state (shift, ctrl, caps lock), translates US-layout set-2 codes, and buffers the output in a small FIFO drained through a valid/ready handshake. It sits between the PS/2 receiver and the terminal input path.

Parameters:
FIFO_DEPTH, 4, output FIFO entries (power of two, >= 4)

Ports:
clk100  in  1  system clock; the only clock
resetn  in  1  synchronous active-low reset
code  in  8  scan-code byte from the receiver
code_valid  in  1  one-cycle strobe; code is valid this cycle
ascii  out  8  FIFO head byte
ascii_valid  out  1  FIFO not empty
ascii_ready  in  1  consumer pops head when ascii_valid & ascii_ready
caps_lock  out  1  current caps-lock state (drives LED logic)
overflow  out  1  sticky: a byte or sequence was dropped

Behaviour:
- Reset (resetn=0 sampled at clk100 edge): FIFO empty, ascii=0, ascii_valid=0, caps_lock=0, overflow=0, all modifiers released, FSM=IDLE. Reset mid-sequence aborts it; no partial bytes remain.
- FSM, advanced only on code_valid:
  - IDLE: E0->EXT; F0->BRK; E1->SKIP (count=7); else process make(code, ext=0).
  - EXT: F0->EXTBRK; else process make(code, ext=1), ->IDLE.
  - BRK: process break(code, ext=0), ->IDLE. EXTBRK: process break(code, ext=1), ->IDLE.
  - SKIP: decrement count per byte; ->IDLE at 0 (Pause sequence discarded, ctrl unaffected).
  - E0/F0 received in an unexpected state: restart the prefix from that byte.
- Modifiers: 12/59 = shift L/R; 14 and E0 14 = ctrl L/R; make sets, break clears, tracked separately. 58 = caps lock: toggle on make only when caps_held=0, then set caps_held; break clears caps_held (typematic repeat does not re-toggle).
- Make translation (non-ext), US layout:
  - Letters a..z = 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A. Uppercase when shift XOR caps_lock.
  - Digits 1..9,0 = 16 1E 26 25 2E 36 3D 3E 46 45; shifted !@#$%^&*().
  - Punctuation 4E - _, 55 = +, 54 [ {, 5B ] }, 5D \ |, 4C ; :, 52 ' ", 41 , <, 49 . >, 4A / ?, 0E ` ~. Caps lock does not affect digits or punctuation.
  - 29 space 20, 5A enter 0D, 66 backspace 08, 0D tab 09, 76 esc 1B.
  - Ctrl held and result is a letter: emit (letter & 1F); ctrl overrides shift/caps.
- Ext make: 75/72/74/6B (up/down/right/left) emit 3-byte sequence 1B 5B {41,42,43,44}; E0 5A emits 0D; E0 4A emits 2F.
- Unmapped codes and all breaks of non-modifiers emit nothing.
- Timing: registered lookup. code_valid at cycle N pushes a single byte at N+1; ascii_valid high at N+2 if the FIFO was empty. A sequence pushes one byte per cycle at N+1..N+3; the FSM is busy during this. A code_valid while busy is dropped and sets overflow.
- Space check: a single byte is pushed only if not full. A sequence is pushed only if free entries >= 3 at N+1, else the whole sequence is dropped. Either drop sets overflow. Drops never partially write.
- FIFO: ascii/ascii_valid come from the head and are stable while ascii_valid & !ascii_ready. A push and pop in the same cycle are both performed, including when full (pop frees the slot). Pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset, then codes 1C, F0 1C with ascii_ready=1 -> exactly one byte 61, ascii_valid 1 cycle pulse at N+2; caps_lock=0, overflow=0.
- 12, 1C, F0 12, 1C -> 41 then 61; then 58, 58, F0 58, 1C -> caps_lock=1 after the first 58 only, output 41.
- 14, 21 -> 03; E0 14, F0 14 (left released, right held), 21 -> 03; E0 F0 14, 21 -> 63.
- ascii_ready=0, E0 75 -> FIFO holds 1B 5B 41 over 3 cycles; E0 72 with 1 free slot -> dropped, overflow=1; then drain -> 1B 5B 41 only.
- E1 14 77 E1 F0 14 F0 77, then 1C -> only 61 emitted, ctrl never seen as held.
- Fill FIFO with ascii_ready=0, assert ready and push 29 in the same cycle -> no overflow, 20 appears last; assert resetn=0 mid-E0 sequence -> FIFO empty, next 1C gives 61.

Source files
------------

// File: rtl/ps2_keymap.sv
// PS/2 set-2 scan-code to ASCII/ANSI translator for the terminal input path.
// Prefix/modifier FSM, registered lookup, and an output FIFO with a valid/ready drain.
module ps2_keymap #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk100,
    input  logic       resetn,
    input  logic [7:0] code,
    input  logic       code_valid,
    output logic [7:0] ascii,
    output logic       ascii_valid,
    input  logic       ascii_ready,
    output logic       caps_lock,
    output logic       overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_W = FIFO_DEPTH[AW:0];
    localparam logic [AW:0] SEQ_LEN = 3;

    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK, S_SKIP} state_t;

    state_t      state, state_nx;
    logic [2:0]  skip_cnt, skip_nx;
    logic        shift_l, shift_r, ctrl_l, ctrl_r, caps_held;
    logic        shift_l_nx, shift_r_nx, ctrl_l_nx, ctrl_r_nx, caps_nx, held_nx;
    logic        busy, accept, do_make, do_brk, key_ext;

    logic        lut_hit, lut_seq, is_letter;
    logic [7:0]  lut_byte;

    logic        pend_valid, seq_pend, seq_run, seq_step;
    logic [7:0]  pend_byte, seq_arrow;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, free_eff;
    logic          full, pop, push, drop, space_seq;
    logic [7:0]    push_byte;

    assign busy   = seq_pend | seq_run;
    assign accept = code_valid & ~busy;

    always_comb begin
        state_nx   = state;
        skip_nx    = skip_cnt;
        shift_l_nx = shift_l;
        shift_r_nx = shift_r;
        ctrl_l_nx  = ctrl_l;
        ctrl_r_nx  = ctrl_r;
        caps_nx    = caps_lock;
        held_nx    = caps_held;
        do_make    = 1'b0;
        do_brk     = 1'b0;
        key_ext    = 1'b0;
        if (accept) begin
            case (state)
                S_IDLE: begin
                    if (code == 8'hE0)      state_nx = S_EXT;
                    else if (code == 8'hF0) state_nx = S_BRK;
                    else if (code == 8'hE1) begin
                        state_nx = S_SKIP;
                        skip_nx  = 3'd7;
                    end else do_make = 1'b1;
                end
                S_EXT: begin
                    if (code == 8'hE0)      state_nx = S_EXT;
                    else if (code == 8'hF0) state_nx = S_EXTBRK;
                    else begin
                        do_make  = 1'b1;
                        key_ext  = 1'b1;
                        state_nx = S_IDLE;
                    end
                end
                S_BRK, S_EXTBRK: begin
                    if (code == 8'hE0)      state_nx = S_EXT;
                    else if (code == 8'hF0) state_nx = S_BRK;
                    else begin
                        do_brk   = 1'b1;
                        key_ext  = (state == S_EXTBRK);
                        state_nx = S_IDLE;
                    end
                end
                S_SKIP: begin
                    skip_nx = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) state_nx = S_IDLE;
                end
                default: state_nx = S_IDLE;
            endcase
            if (do_make || do_brk) begin
                case ({key_ext, code})
                    9'h012: shift_l_nx = do_make;
                    9'h059: shift_r_nx = do_make;
                    9'h014: ctrl_l_nx  = do_make;
                    9'h114: ctrl_r_nx  = do_make;
                    9'h058: begin
                        // Toggle only on the first make so typematic repeats are ignored
                        if (do_make) begin
                            if (!caps_held) caps_nx = ~caps_lock;
                            held_nx = 1'b1;
                        end else begin
                            held_nx = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        lut_hit   = 1'b1;
        lut_seq   = 1'b0;
        is_letter = 1'b0;
        lut_byte  = '0;
        if (key_ext) begin
            case (code)
                8'h75: begin lut_seq = 1'b1; lut_byte = 8'h41; end
                8'h72: begin lut_seq = 1'b1; lut_byte = 8'h42; end
                8'h74: begin lut_seq = 1'b1; lut_byte = 8'h43; end
                8'h6B: begin lut_seq = 1'b1; lut_byte = 8'h44; end
                8'h5A: lut_byte = 8'h0D;
                8'h4A: lut_byte = 8'h2F;
                default: lut_hit = 1'b0;
            endcase
        end else begin
            case (code)
                8'h1C: begin is_letter = 1'b1; lut_byte = 8'h61; end
                8'h32: begin is_letter = 1'b1; lut_byte = 8'h62; end
                8'h21: begin is_letter = 1'b1; lut_byte = 8'h63; end
                8'h23: begin is_letter = 1'b1; lut_byte = 8'h64; end
                8'h24: begin is_letter = 1'b1; lut_byte = 8'h65; end
                8'h2B: begin is_letter = 1'b1; lut_byte = 8'h66; end
                8'h34: begin is_letter = 1'b1; lut_byte = 8'h67; end
                8'h33: begin is_letter = 1'b1; lut_byte = 8'h68; end
                8'h43: begin is_letter = 1'b1; lut_byte = 8'h69; end
                8'h3B: begin is_letter = 1'b1; lut_byte = 8'h6A; end
                8'h42: begin is_letter = 1'b1; lut_byte = 8'h6B; end
                8'h4B: begin is_letter = 1'b1; lut_byte = 8'h6C; end
                8'h3A: begin is_letter = 1'b1; lut_byte = 8'h6D; end
                8'h31: begin is_letter = 1'b1; lut_byte = 8'h6E; end
                8'h44: begin is_letter = 1'b1; lut_byte = 8'h6F; end
                8'h4D: begin is_letter = 1'b1; lut_byte = 8'h70; end
                8'h15: begin is_letter = 1'b1; lut_byte = 8'h71; end
                8'h2D: begin is_letter = 1'b1; lut_byte = 8'h72; end
                8'h1B: begin is_letter = 1'b1; lut_byte = 8'h73; end
                8'h2C: begin is_letter = 1'b1; lut_byte = 8'h74; end
                8'h3C: begin is_letter = 1'b1; lut_byte = 8'h75; end
                8'h2A: begin is_letter = 1'b1; lut_byte = 8'h76; end
                8'h1D: begin is_letter = 1'b1; lut_byte = 8'h77; end
                8'h22: begin is_letter = 1'b1; lut_byte = 8'h78; end
                8'h35: begin is_letter = 1'b1; lut_byte = 8'h79; end
                8'h1A: begin is_letter = 1'b1; lut_byte = 8'h7A; end
                8'h16: lut_byte = (shift_l | shift_r) ? 8'h21 : 8'h31;
                8'h1E: lut_byte = (shift_l | shift_r) ? 8'h40 : 8'h32;
                8'h26: lut_byte = (shift_l | shift_r) ? 8'h23 : 8'h33;
                8'h25: lut_byte = (shift_l | shift_r) ? 8'h24 : 8'h34;
                8'h2E: lut_byte = (shift_l | shift_r) ? 8'h25 : 8'h35;
                8'h36: lut_byte = (shift_l | shift_r) ? 8'h5E : 8'h36;
                8'h3D: lut_byte = (shift_l | shift_r) ? 8'h26 : 8'h37;
                8'h3E: lut_byte = (shift_l | shift_r) ? 8'h2A : 8'h38;
                8'h46: lut_byte = (shift_l | shift_r) ? 8'h28 : 8'h39;
                8'h45: lut_byte = (shift_l | shift_r) ? 8'h29 : 8'h30;
                8'h4E: lut_byte = (shift_l | shift_r) ? 8'h5F : 8'h2D;
                8'h55: lut_byte = (shift_l | shift_r) ? 8'h2B : 8'h3D;
                8'h54: lut_byte = (shift_l | shift_r) ? 8'h7B : 8'h5B;
                8'h5B: lut_byte = (shift_l | shift_r) ? 8'h7D : 8'h5D;
                8'h5D: lut_byte = (shift_l | shift_r) ? 8'h7C : 8'h5C;
                8'h4C: lut_byte = (shift_l | shift_r) ? 8'h3A : 8'h3B;
                8'h52: lut_byte = (shift_l | shift_r) ? 8'h22 : 8'h27;
                8'h41: lut_byte = (shift_l | shift_r) ? 8'h3C : 8'h2C;
                8'h49: lut_byte = (shift_l | shift_r) ? 8'h3E : 8'h2E;
                8'h4A: lut_byte = (shift_l | shift_r) ? 8'h3F : 8'h2F;
                8'h0E: lut_byte = (shift_l | shift_r) ? 8'h7E : 8'h60;
                8'h29: lut_byte = 8'h20;
                8'h5A: lut_byte = 8'h0D;
                8'h66: lut_byte = 8'h08;
                8'h0D: lut_byte = 8'h09;
                8'h76: lut_byte = 8'h1B;
                default: lut_hit = 1'b0;
            endcase
            if (is_letter) begin
                if (ctrl_l | ctrl_r)                     lut_byte = lut_byte & 8'h1F;
                else if ((shift_l | shift_r) ^ caps_lock) lut_byte = lut_byte & 8'hDF;
            end
        end
    end

    assign pop         = ascii_valid & ascii_ready;
    assign full        = (count == DEPTH_W);
    assign free_eff    = DEPTH_W - count + {{AW{1'b0}}, pop};
    assign space_seq   = (free_eff >= SEQ_LEN);
    assign ascii_valid = (count != '0);
    assign ascii       = ascii_valid ? mem[rd_ptr] : '0;

    // A sequence reserves all three slots up front, so its later bytes never need a space check
    always_comb begin
        push      = 1'b0;
        drop      = 1'b0;
        push_byte = '0;
        if (pend_valid) begin
            if (!full || pop) begin
                push      = 1'b1;
                push_byte = pend_byte;
            end else drop = 1'b1;
        end else if (seq_pend) begin
            if (space_seq) begin
                push      = 1'b1;
                push_byte = 8'h1B;
            end else drop = 1'b1;
        end else if (seq_run) begin
            push      = 1'b1;
            push_byte = seq_step ? seq_arrow : 8'h5B;
        end
    end

    always_ff @(posedge clk100) begin
        if (push) mem[wr_ptr] <= push_byte;
    end

    always_ff @(posedge clk100) begin
        if (!resetn) begin
            state      <= S_IDLE;
            skip_cnt   <= '0;
            shift_l    <= 1'b0;
            shift_r    <= 1'b0;
            ctrl_l     <= 1'b0;
            ctrl_r     <= 1'b0;
            caps_lock  <= 1'b0;
            caps_held  <= 1'b0;
            pend_valid <= 1'b0;
            pend_byte  <= '0;
            seq_pend   <= 1'b0;
            seq_run    <= 1'b0;
            seq_step   <= 1'b0;
            seq_arrow  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nx;
            skip_cnt   <= skip_nx;
            shift_l    <= shift_l_nx;
            shift_r    <= shift_r_nx;
            ctrl_l     <= ctrl_l_nx;
            ctrl_r     <= ctrl_r_nx;
            caps_lock  <= caps_nx;
            caps_held  <= held_nx;
            pend_valid <= do_make & lut_hit & ~lut_seq;
            pend_byte  <= lut_byte;
            seq_pend   <= do_make & lut_hit & lut_seq;
            if (do_make && lut_seq) seq_arrow <= lut_byte;
            if (seq_pend && space_seq) begin
                seq_run  <= 1'b1;
                seq_step <= 1'b0;
            end else if (seq_run) begin
                if (seq_step) seq_run <= 1'b0;
                seq_step <= 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop || (code_valid && busy)) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_keymap.sv
// Scoreboard bench for ps2_keymap: directed scan-code vectors with hand-computed bytes,
// a negedge monitor popping the expected queue on each FIFO handshake.
module tb_ps2_keymap;

    logic       clk100 = 1'b0;
    logic       resetn;
    logic [7:0] code;
    logic       code_valid;
    logic [7:0] ascii;
    logic       ascii_valid;
    logic       ascii_ready;
    logic       caps_lock;
    logic       overflow;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [7:0]  exp_q [$];

    ps2_keymap #(.FIFO_DEPTH(4)) dut (
        .clk100      (clk100),
        .resetn      (resetn),
        .code        (code),
        .code_valid  (code_valid),
        .ascii       (ascii),
        .ascii_valid (ascii_valid),
        .ascii_ready (ascii_ready),
        .caps_lock   (caps_lock),
        .overflow    (overflow)
    );

    always #5 clk100 = ~clk100;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    endtask

    // Monitor: inputs change 1ns after posedge, so negedge shows what the next edge will pop
    always @(negedge clk100) begin
        if (resetn && ascii_valid && ascii_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", ascii, 8'hxx);
            end else begin
                chk("fifo_byte", ascii, exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        resetn     = 1'b0;
        code_valid = 1'b0;
        code       = '0;
        @(posedge clk100);
        @(posedge clk100);
        #1 resetn = 1'b1;
        exp_q.delete();
    endtask

    task automatic send(input logic [7:0] c);
        @(posedge clk100);
        #1 code = c; code_valid = 1'b1;
        @(posedge clk100);
        #1 code_valid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(posedge clk100);
        #1;
    endtask

    task automatic drain(input string name);
        int unsigned budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            @(posedge clk100);
            budget++;
        end
        #1;
        idle(3);
        chk(name, 8'(exp_q.size()), 8'h00);
        chk({name, "_empty"}, {7'd0, ascii_valid}, 8'h00);
    endtask

    initial begin
        ascii_ready = 1'b1;
        do_reset();
        chk("rst_ascii", ascii, 8'h00);
        chk("rst_valid", {7'd0, ascii_valid}, 8'h00);
        chk("rst_caps", {7'd0, caps_lock}, 8'h00);
        chk("rst_ovf", {7'd0, overflow}, 8'h00);

        // Single make: byte visible two cycles after the strobe, one-cycle pulse when ready
        exp_q.push_back(8'h61);
        send(8'h1C);
        chk("lat_n1_valid", {7'd0, ascii_valid}, 8'h00);
        @(posedge clk100); #1;
        chk("lat_n2_valid", {7'd0, ascii_valid}, 8'h01);
        chk("lat_n2_byte", ascii, 8'h61);
        @(posedge clk100); #1;
        chk("lat_n3_valid", {7'd0, ascii_valid}, 8'h00);
        send(8'hF0); send(8'h1C);
        drain("t1_drain");
        chk("t1_caps", {7'd0, caps_lock}, 8'h00);
        chk("t1_ovf", {7'd0, overflow}, 8'h00);

        // Shift and caps lock with typematic repeat
        do_reset();
        send(8'h12); exp_q.push_back(8'h41); send(8'h1C);
        send(8'hF0); send(8'h12); exp_q.push_back(8'h61); send(8'h1C);
        send(8'h58);
        chk("caps_first", {7'd0, caps_lock}, 8'h01);
        send(8'h58);
        chk("caps_repeat", {7'd0, caps_lock}, 8'h01);
        send(8'hF0); send(8'h58);
        chk("caps_break", {7'd0, caps_lock}, 8'h01);
        exp_q.push_back(8'h41); send(8'h1C);
        drain("t2_drain");

        // Left/right ctrl tracked independently
        do_reset();
        send(8'h14); exp_q.push_back(8'h03); send(8'h21);
        send(8'hE0); send(8'h14); send(8'hF0); send(8'h14);
        exp_q.push_back(8'h03); send(8'h21);
        send(8'hE0); send(8'hF0); send(8'h14);
        exp_q.push_back(8'h63); send(8'h21);
        drain("t3_drain");

        // Arrow sequence, then a second one rejected for lack of space
        do_reset();
        ascii_ready = 1'b0;
        send(8'hE0);
        exp_q.push_back(8'h1B); exp_q.push_back(8'h5B); exp_q.push_back(8'h41);
        send(8'h75);
        idle(4);
        chk("seq_ovf_before", {7'd0, overflow}, 8'h00);
        send(8'hE0); send(8'h72);
        idle(4);
        chk("seq_ovf_after", {7'd0, overflow}, 8'h01);
        ascii_ready = 1'b1;
        drain("t4_drain");

        // Pause sequence swallowed without touching ctrl
        do_reset();
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        exp_q.push_back(8'h61); send(8'h1C);
        drain("t5_drain");

        // Full FIFO with simultaneous pop and push
        do_reset();
        ascii_ready = 1'b0;
        exp_q.push_back(8'h61); send(8'h1C);
        exp_q.push_back(8'h62); send(8'h32);
        exp_q.push_back(8'h63); send(8'h21);
        exp_q.push_back(8'h64); send(8'h23);
        idle(2);
        exp_q.push_back(8'h20); send(8'h29);
        ascii_ready = 1'b1;
        drain("t6_drain");
        chk("t6_ovf", {7'd0, overflow}, 8'h00);

        // Reset in the middle of an extended prefix with data queued
        ascii_ready = 1'b0;
        send(8'h1C); send(8'hE0);
        do_reset();
        chk("midrst_valid", {7'd0, ascii_valid}, 8'h00);
        ascii_ready = 1'b1;
        exp_q.push_back(8'h61); send(8'h1C);
        drain("t7_drain");

        // Caps leaves digits alone; shifted punctuation; extended keypad keys
        do_reset();
        send(8'h58);
        exp_q.push_back(8'h31); send(8'h16);
        send(8'h12);
        exp_q.push_back(8'h3F); send(8'h4A);
        exp_q.push_back(8'h61); send(8'h1C);
        exp_q.push_back(8'h21); send(8'h16);
        send(8'hF0); send(8'h12);
        send(8'hE0); exp_q.push_back(8'h2F); send(8'h4A);
        send(8'hE0); exp_q.push_back(8'h0D); send(8'h5A);
        exp_q.push_back(8'h08); send(8'h66);
        exp_q.push_back(8'h5D); send(8'h5B);
        drain("t8_drain");
        chk("t8_ovf", {7'd0, overflow}, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
